// File: rtl/fib_trace_fifo.sv
// -----------------------------------------------------------------------------
// fib_trace_fifo
//
// Capture stage sitting behind the fib_14 core. Every clock with capture_en
// high the tuple {selector, a, j, m} is offered to a first-word-fall-through
// FIFO. With CHANGE_ONLY=1 a tuple identical to the last *stored* tuple is not
// offered again. The FIFO drains through a valid/ready port to the trace
// writer. Pushes arriving while the FIFO is full (and not being popped in the
// same cycle) are dropped, flagged on the sticky overflow output and counted
// in a saturating drop counter.
//
// Optional feature macro: FIB_TRACE_TIMESTAMP_EN
//   When defined, a 16-bit free-running cycle counter is added, each stored
//   entry carries the counter value of its sampling cycle, and the head
//   entry's stamp is presented on out_ts. Stamps take no part in the
//   change filter.
//
// Parameters:
//   W           width of a/j/m
//   DEPTH       FIFO entries (power of two, >= 2)
//   CHANGE_ONLY 1: store only tuples that differ from the last stored one
//   CNT_W       width of drop_cnt
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   capture_en        sampling enable
//   selector, a, j, m tuple sampled this cycle
//   out_valid/ready   FWFT drain handshake
//   out_sel/a/j/m     head entry (meaningful only while out_valid=1)
//   level, full       occupancy 0..DEPTH, full when level == DEPTH
//   overflow          sticky: at least one push was dropped since reset
//   drop_cnt          number of dropped pushes, saturating
//   out_ts            head entry timestamp (FIB_TRACE_TIMESTAMP_EN only)
// -----------------------------------------------------------------------------
module fib_trace_fifo #(
  parameter int W           = 11,
  parameter int DEPTH       = 16,
  parameter int CHANGE_ONLY = 1,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     capture_en,
  input  logic                     selector,
  input  logic [W-1:0]             a,
  input  logic [W-1:0]             j,
  input  logic [W-1:0]             m,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sel,
  output logic [W-1:0]             out_a,
  output logic [W-1:0]             out_j,
  output logic [W-1:0]             out_m,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt
`ifdef FIB_TRACE_TIMESTAMP_EN
  ,
  output logic [15:0]              out_ts
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = 1 + 3 * W;
`ifdef FIB_TRACE_TIMESTAMP_EN
  localparam int EW = TW + 16;
`else
  localparam int EW = TW;
`endif
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [TW-1:0]    tuple;
  logic [EW-1:0]    wr_entry;
  logic [EW-1:0]    rd_entry;
  logic [EW-1:0]    mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [TW-1:0]    last_q, last_d;
  logic             last_vld_q, last_vld_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             push_req;
  logic             pop;
  logic             push_acc;
  logic             drop;

  assign tuple = {selector, a, j, m};

`ifdef FIB_TRACE_TIMESTAMP_EN
  logic [15:0] ts_q, ts_d;

  assign ts_d     = ts_q + 16'd1;
  assign wr_entry = {ts_q, tuple};

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end
`else
  assign wr_entry = tuple;
`endif

  always_comb begin
    push_req = capture_en &&
               ((CHANGE_ONLY == 0) || !last_vld_q || (tuple != last_q));
    pop      = (level_q != '0) && out_ready;
    // When full, a push still fits if the head leaves in the same cycle:
    // the write lands in the slot the read is vacating.
    push_acc = push_req && ((level_q != FULL_LVL) || pop);
    drop     = push_req && !push_acc;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push_acc) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      last_d     = tuple;
      last_vld_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push_acc, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage has no reset; occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (!rst && push_acc) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign rd_entry  = mem_q[rd_ptr_q];

  assign out_m     = rd_entry[W-1:0];
  assign out_j     = rd_entry[2*W-1:W];
  assign out_a     = rd_entry[3*W-1:2*W];
  assign out_sel   = rd_entry[3*W];
`ifdef FIB_TRACE_TIMESTAMP_EN
  assign out_ts    = rd_entry[EW-1:TW];
`endif

  assign out_valid = (level_q != '0);
  assign full      = (level_q == FULL_LVL);
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fib_trace_fifo.sv
// -----------------------------------------------------------------------------
// tb_fib_trace_fifo
//
// Scoreboard bench for fib_trace_fifo (default parameters, timestamp feature
// off). The driver applies one cycle of stimulus, then updates a queue-based
// reference model at the rising edge and appends every accepted tuple to the
// expected queue. An independent monitor on the falling edge compares status
// outputs with the model, compares the head entry with the front of the
// expected queue, and retires that entry whenever a handshake will occur.
// -----------------------------------------------------------------------------
module tb_fib_trace_fifo;

  localparam int W     = 11;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int TW    = 1 + 3 * W;

  logic             clk;
  logic             rst;
  logic             capture_en;
  logic             selector;
  logic [W-1:0]     a, j, m;
  logic             out_valid;
  logic             out_ready;
  logic             out_sel;
  logic [W-1:0]     out_a, out_j, out_m;
  logic [LW-1:0]    level;
  logic             full;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;

  fib_trace_fifo #(
    .W(W), .DEPTH(DEPTH), .CHANGE_ONLY(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .capture_en(capture_en), .selector(selector),
    .a(a), .j(j), .m(m),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
    .out_a(out_a), .out_j(out_j), .out_m(out_m),
    .level(level), .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  logic [TW-1:0] exp_q[$];
  int            mlevel;
  logic [TW-1:0] mlast;
  bit            mlast_vld;
  bit            movf;
  int            mdrop;
  bit            armed;

  int checks;
  int errors;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // One clock of stimulus; the model advances at the rising edge using the
  // state it held before that edge.
  task automatic cyc(input logic r, input logic en, input logic s,
                     input logic [W-1:0] ia, input logic [W-1:0] ij,
                     input logic [W-1:0] im, input logic rdy);
    logic [TW-1:0] tup;
    bit            pop;
    rst        = r;
    capture_en = en;
    selector   = s;
    a          = ia;
    j          = ij;
    m          = im;
    out_ready  = rdy;
    @(posedge clk);
    tup = {s, ia, ij, im};
    if (r) begin
      exp_q.delete();
      mlevel    = 0;
      mlast_vld = 0;
      mlast     = '0;
      movf      = 0;
      mdrop     = 0;
      armed     = 1;
    end else begin
      pop = (mlevel != 0) && rdy;
      if (pop) mlevel--;
      if (en && (!mlast_vld || tup != mlast)) begin
        if (mlevel < DEPTH) begin
          exp_q.push_back(tup);
          mlevel++;
          mlast     = tup;
          mlast_vld = 1;
        end else begin
          movf = 1;
          if (mdrop < (1 << CNT_W) - 1) mdrop++;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, rdy);
  endtask

  // monitor
  always @(negedge clk) begin
    if (armed) begin
      chk("level", 64'(level), 64'(mlevel));
      chk("full", 64'(full), 64'(mlevel == DEPTH));
      chk("out_valid", 64'(out_valid), 64'(mlevel != 0));
      chk("overflow", 64'(overflow), 64'(movf));
      chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL head actual=valid required=empty");
        end else begin
          chk("head", 64'({out_sel, out_a, out_j, out_m}), 64'(exp_q[0]));
          if (out_ready && !rst) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    armed  = 0;
    mlevel = 0;
    mlast_vld = 0;
    mlast = '0;
    movf = 0;
    mdrop = 0;

    // reset, then empty drain
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    idle(5, 1'b1);

    // single capture latency, then consume
    cyc(1'b0, 1'b1, 1'b1, W'(5), W'(8), W'(13), 1'b0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    idle(2, 1'b0);

    // change filter: repeated tuple stored once
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b0, W'(3), W'(5), W'(8), 1'b0);
    cyc(1'b0, 1'b1, 1'b0, W'(5), W'(5), W'(8), 1'b0);
    idle(1, 1'b0);
    chk("filter_level", 64'(level), 64'd2);
    idle(3, 1'b1);

    // overflow: 20 distinct tuples into a 16-deep FIFO
    for (int k = 0; k < 20; k++)
      cyc(1'b0, 1'b1, 1'(k & 1), W'(100 + k), W'(k), W'(7), 1'b0);
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd4);
    chk("ovf_full", 64'(full), 64'd1);
    // full with simultaneous push and pop
    cyc(1'b0, 1'b1, 1'b0, W'(500), W'(1), W'(1), 1'b1);
    chk("fullpp_level", 64'(level), 64'(DEPTH));
    idle(20, 1'b1);

    // random traffic; pointers wrap several times, later half overflows
    for (int k = 0; k < 300; k++)
      cyc(1'b0, ($urandom_range(3) != 0), 1'($urandom_range(1)),
          W'($urandom_range(3)), W'($urandom_range(2)), W'($urandom_range(1)),
          (k < 150) ? ($urandom_range(1) == 1) : ($urandom_range(3) == 0));
    idle(20, 1'b1);

    // mid-operation reset with 7 entries and a pending handshake
    for (int k = 0; k < 7; k++)
      cyc(1'b0, 1'b1, 1'b1, W'(200 + k), W'(k), W'(3), 1'b0);
    chk("pre_rst_level", 64'(level), 64'd7);
    cyc(1'b1, 1'b1, 1'b0, W'(9), W'(9), W'(9), 1'b1);
    chk("post_rst_level", 64'(level), 64'd0);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_ovf", 64'(overflow), 64'd0);
    cyc(1'b0, 1'b1, 1'b0, W'(9), W'(9), W'(9), 1'b0);
    idle(3, 1'b1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
